rotate_iter_ctrl: RTL
=====================

# rotate_iter_ctrl

Iterative rotate controller that sits directly upstream of the 4-bit barrel rotator and also consumes its output. It accepts a command, made of a data word, a per-step rotate amount and a repeat count, over a valid/ready handshake. It drives the rotator's `in`/`no_of_bits` inputs and feeds the rotator output back for the requested number of steps. It then presents the final word on a valid/ready result port. Rotate direction is set by the rotator's own `MODE` parameter; this block does not depend on direction.

## Interface
- `SIZE`, 4, data width; only 4 is supported, because the rotator is fixed at 4 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_data`  in  SIZE  word to rotate.
- `cmd_amt`  in  2  rotate amount per step (0..3).
- `cmd_rep`  in  3  number of steps minus 1 (0..7 gives 1..8 steps).
- `sh_in`  out  SIZE  to rotator `in`.
- `sh_bits`  out  2  to rotator `no_of_bits`.
- `sh_out`  in  SIZE  from rotator `out`; purely combinational path.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  SIZE  final rotated word.
- `res_rot`  out  2  net rotation applied, equal to `(cmd_amt*(cmd_rep+1)) mod 4`.
- `busy`  out  1  high in RUN or DONE.

## Operation
- **Registers:**
  - `acc[SIZE-1:0]`, `amt[1:0]`, `cnt[2:0]`, `rot[1:0]`, `state`.
  - `sh_in=acc` and `sh_bits=amt` in all states.
  - `res_data=acc` and `res_rot=rot`.
- **FSM states:**
  - **IDLE:**
    - `cmd_ready=1` (forced 0 while `rst` high).
    - On `cmd_valid&&cmd_ready`: `acc<=cmd_data`, `amt<=cmd_amt`, `cnt<=cmd_rep`, `rot<=0`, then go to RUN.
  - **RUN:**
    - Every cycle: `acc<=sh_out` and `rot<=rot+amt` (2-bit wrap).
    - If `cnt==0`, go to DONE; else `cnt<=cnt-1`.
    - `cmd_ready=0` and `res_valid=0`.
  - **DONE:**
    - `res_valid=1`; `acc` and `rot` are frozen.
    - On `res_ready`, go to IDLE.
- **No overlap:** a new command is never accepted in RUN or DONE. `cmd_data`, `cmd_amt` and `cmd_rep` are ignored when not accepted.
- **`cmd_amt=0`:** still takes `cmd_rep+1` RUN cycles; `res_data=cmd_data` and `res_rot=0`.
- **`cnt` underflow:** impossible; the FSM leaves RUN when `cnt` reaches 0.
- **`rot` arithmetic:** modulo 4; overflow is discarded.
- **Reset (asynchronous, any state including mid-RUN):**
  - State goes to IDLE; `acc`, `amt`, `cnt`, `rot` go to 0.
  - `sh_in=0`, `sh_bits=0`, `res_valid=0`, `res_data=0`, `res_rot=0`, `busy=0`, `cmd_ready=0` while `rst` is high.
  - `cmd_ready=1` from the first cycle after deassertion.
  - A partially rotated word is discarded; no result is produced for the aborted command.

## Timing
- A command is accepted at edge T0. RUN occupies edges T1..T(rep+1). `res_valid` rises after edge T(rep+1), so latency is `cmd_rep+1` cycles from acceptance to result valid.
- The result handshake completes at the edge where `res_valid&&res_ready`. IDLE follows for at least one cycle, so the next command is accepted one edge later at the earliest.
- Peak throughput is one command per `cmd_rep+3` cycles.
- The `sh_out` to `acc` path is one combinational rotator delay and must close in one cycle.
- `cmd_ready`, `res_valid`, `busy`, `res_data` and `res_rot` are decoded from registered state only and have no combinational dependence on `cmd_valid` or `res_ready`.
- `res_data` and `res_rot` are stable for the whole time `res_valid` is high.

## Test plan
All scenarios are run with the rotator instantiated with `MODE=1` (right rotate).
- **Multi-step rotate:** `cmd_data=4'b0001`, `amt=1`, `rep=2`.
  - `sh_in` sequence 0001, 1000, 0100.
  - `res_data=4'b0010` and `res_rot=3`.
  - `res_valid` rises 3 cycles after acceptance.
- **Net-zero rotation:** `cmd_data=4'b1011`, `amt=2`, `rep=1` → `res_data=4'b1011`, `res_rot=0`, latency 2 cycles.
- **Backpressure:** hold `res_ready=0` for 5 cycles in DONE.
  - `res_valid` stays 1; `res_data` and `res_rot` are unchanged; `cmd_ready=0`.
  - A `cmd_valid` pulse during this window is ignored.
  - Releasing `res_ready` returns to IDLE.
- **Back-to-back commands:** `cmd_valid` held high with two commands, `res_ready=1`.
  - The second command is accepted exactly 1 cycle after the first result handshake.
  - Both results are correct; `amt=3`, `rep=7` on `4'b0110` gives `res_data=4'b0110`, `res_rot=0`.
- **Reset mid-RUN:** assert `rst` asynchronously (between clock edges) during the 4th RUN cycle of `rep=7`.
  - Outputs go to 0 immediately; no `res_valid` appears.
  - After deassertion, `cmd_ready=1` and a fresh command `4'b1000`, `amt=1`, `rep=0` gives `4'b0100`.

Source files
------------

// File: rtl/rotate_iter_ctrl.sv
// Iterative rotate controller wrapped around an external 4-bit barrel rotator; result valid cmd_rep+1 cycles after acceptance.
// One command in flight; cmd_ready low in RUN/DONE, and DONE holds the result until res_ready.
module rotate_iter_ctrl #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SIZE-1:0] cmd_data,
    input  logic [1:0]      cmd_amt,
    input  logic [2:0]      cmd_rep,
    output logic [SIZE-1:0] sh_in,
    output logic [1:0]      sh_bits,
    input  logic [SIZE-1:0] sh_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SIZE-1:0] res_data,
    output logic [1:0]      res_rot,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [SIZE-1:0] acc;
    logic [1:0]      amt;
    logic [2:0]      cnt;
    logic [1:0]      rot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            amt   <= '0;
            cnt   <= '0;
            rot   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        acc   <= cmd_data;
                        amt   <= cmd_amt;
                        cnt   <= cmd_rep;
                        rot   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= sh_out;
                    rot <= rot + amt;
                    if (cnt == 3'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset already forces state to IDLE; rst is folded in only to hold cmd_ready low during reset.
    assign cmd_ready = (state == IDLE) && !rst;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sh_in     = acc;
    assign sh_bits   = amt;
    assign res_data  = acc;
    assign res_rot   = rot;

endmodule
